rr_l2_arbiter: RTL and testbench

RR_L2_ARBITER -- requirements
Module: rr_l2_arbiter

---
 rtl/rr_l2_arbiter_if.sv | 45 ++++
 rtl/rr_l2_arbiter.sv | 114 +++++++++++
 tb/tb_rr_l2_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_l2_arbiter_if.sv
// Bundle of the I-cache, D-cache and L2 line-transfer signals around the arbiter.
// master: the caches and L2 memory; slave: the arbiter.
interface rr_l2_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128
);
   logic              imem_read;
   logic              imem_write;
   logic [ADDR_W-1:0] imem_address;
   logic [LINE_W-1:0] imem_wdata;
   logic [LINE_W-1:0] imem_rdata;
   logic              imem_resp;

   logic              dmem_read;
   logic              dmem_write;
   logic [ADDR_W-1:0] dmem_address;
   logic [LINE_W-1:0] dmem_wdata;
   logic [LINE_W-1:0] dmem_rdata;
   logic              dmem_resp;

   logic              L2_mem_read;
   logic              L2_mem_write;
   logic [ADDR_W-1:0] L2_mem_address;
   logic [LINE_W-1:0] L2_mem_wdata;
   logic [LINE_W-1:0] L2_mem_rdata;
   logic              L2_mem_resp;

   modport master (
      output imem_read, imem_write, imem_address, imem_wdata,
      input  imem_rdata, imem_resp,
      output dmem_read, dmem_write, dmem_address, dmem_wdata,
      input  dmem_rdata, dmem_resp,
      input  L2_mem_read, L2_mem_write, L2_mem_address, L2_mem_wdata,
      output L2_mem_rdata, L2_mem_resp
   );

   modport slave (
      input  imem_read, imem_write, imem_address, imem_wdata,
      output imem_rdata, imem_resp,
      input  dmem_read, dmem_write, dmem_address, dmem_wdata,
      output dmem_rdata, dmem_resp,
      output L2_mem_read, L2_mem_write, L2_mem_address, L2_mem_wdata,
      input  L2_mem_rdata, L2_mem_resp
   );
endinterface

// File: rtl/rr_l2_arbiter.sv
// Round-robin arbiter sharing one L2 line port between the I-cache and D-cache.
// One transaction at a time: IDLE grants, SERVE waits for L2, DONE pulses the owner's resp.
module rr_l2_arbiter #(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128
) (
   input  logic            clk,
   input  logic            rst,
   rr_l2_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_SERVE,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_owner;
   logic              r_last_grant;
   logic [LINE_W-1:0] r_line;
   logic              r_l2_read;
   logic              r_l2_write;
   logic [ADDR_W-1:0] r_l2_addr;
   logic [LINE_W-1:0] r_l2_wdata;

   logic              w_i_req;
   logic              w_d_req;
   logic              w_grant;
   logic              w_sel;
   logic              w_sel_read;
   logic              w_sel_write;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [LINE_W-1:0] w_sel_wdata;
   logic              w_l2_done;

   assign w_i_req   = bus.imem_read | bus.imem_write;
   assign w_d_req   = bus.dmem_read | bus.dmem_write;
   assign w_l2_done = (r_state == S_SERVE) && bus.L2_mem_resp;

   always_comb begin
      w_next  = r_state;
      w_grant = 1'b0;
      w_sel   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_i_req || w_d_req) begin
               w_grant = 1'b1;
               // On contention the requester that did not win last time goes first.
               w_sel   = (w_i_req && w_d_req) ? ~r_last_grant : w_d_req;
               w_next  = S_SERVE;
            end
         end
         S_SERVE: begin
            if (bus.L2_mem_resp) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_comb begin
      w_sel_read  = w_sel ? bus.dmem_read    : bus.imem_read;
      w_sel_write = (w_sel ? bus.dmem_write  : bus.imem_write) & ~w_sel_read;
      w_sel_addr  = w_sel ? bus.dmem_address : bus.imem_address;
      w_sel_wdata = w_sel ? bus.dmem_wdata   : bus.imem_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner      <= 1'b0;
         r_last_grant <= 1'b0;
         r_line       <= '0;
         r_l2_read    <= 1'b0;
         r_l2_write   <= 1'b0;
         r_l2_addr    <= '0;
         r_l2_wdata   <= '0;
      end else if (w_grant) begin
         r_owner      <= w_sel;
         r_last_grant <= w_sel;
         r_l2_read    <= w_sel_read;
         r_l2_write   <= w_sel_write;
         r_l2_addr    <= w_sel_addr;
         r_l2_wdata   <= w_sel_wdata;
      end else if (w_l2_done) begin
         r_line       <= bus.L2_mem_rdata;
         r_l2_read    <= 1'b0;
         r_l2_write   <= 1'b0;
      end
   end

   assign bus.L2_mem_read    = r_l2_read;
   assign bus.L2_mem_write   = r_l2_write;
   assign bus.L2_mem_address = r_l2_addr;
   assign bus.L2_mem_wdata   = r_l2_wdata;
   assign bus.imem_rdata     = r_line;
   assign bus.dmem_rdata     = r_line;
   assign bus.imem_resp      = (r_state == S_DONE) && !r_owner;
   assign bus.dmem_resp      = (r_state == S_DONE) &&  r_owner;
endmodule

// File: tb/tb_rr_l2_arbiter.sv
// Bench for rr_l2_arbiter: directed scenarios then random traffic, checked by a
// negedge monitor against a transaction-level model and a response scoreboard.
module tb_rr_l2_arbiter;
   localparam int ADDR_W = 16;
   localparam int LINE_W = 128;

   typedef struct {
      bit                owner;
      logic [LINE_W-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   exp_t sb[$];
   int   rd_idx = 0;

   bit                m_idle       = 1'b1;
   bit                m_last       = 1'b0;
   bit                expect_grant = 1'b0;
   bit                exp_owner    = 1'b0;
   bit                due          = 1'b0;
   bit                prev_l2      = 1'b0;
   logic              exp_rd;
   logic              exp_wr;
   logic [ADDR_W-1:0] exp_addr;
   logic [LINE_W-1:0] exp_wdata;

   always #5 clk = ~clk;

   rr_l2_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

   rr_l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic void chk(input string name, input logic [LINE_W-1:0] act,
                               input logic [LINE_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Monitor: grant choice, one-cycle grant latency, L2 hold, response timing/data.
   always @(negedge clk) begin
      logic cur_l2, got, i_req, d_req;
      cur_l2 = bus.L2_mem_read | bus.L2_mem_write;
      got    = bus.imem_resp | bus.dmem_resp;
      if (rst) begin
         chk("rst_l2_read",  bus.L2_mem_read, 0);
         chk("rst_l2_write", bus.L2_mem_write, 0);
         chk("rst_l2_addr",  bus.L2_mem_address, 0);
         chk("rst_l2_wdata", bus.L2_mem_wdata, 0);
         chk("rst_imem_resp", bus.imem_resp, 0);
         chk("rst_dmem_resp", bus.dmem_resp, 0);
         chk("rst_rdata", bus.dmem_rdata | bus.imem_rdata, 0);
         m_idle       = 1'b1;
         m_last       = 1'b0;
         expect_grant = 1'b0;
         due          = 1'b0;
         prev_l2      = 1'b0;
         rd_idx       = sb.size();
      end else begin
         if (expect_grant) begin
            chk("grant_latency", cur_l2 & ~prev_l2, 1);
            chk("grant_addr",  bus.L2_mem_address, exp_addr);
            chk("grant_read",  bus.L2_mem_read, exp_rd);
            chk("grant_write", bus.L2_mem_write, exp_wr);
            chk("grant_wdata", bus.L2_mem_wdata, exp_wdata);
            m_last       = exp_owner;
            expect_grant = 1'b0;
         end else if (cur_l2 && prev_l2) begin
            chk("hold_addr",  bus.L2_mem_address, exp_addr);
            chk("hold_read",  bus.L2_mem_read, exp_rd);
            chk("hold_write", bus.L2_mem_write, exp_wr);
            chk("hold_wdata", bus.L2_mem_wdata, exp_wdata);
         end else begin
            chk("spurious_l2", cur_l2 & ~prev_l2, 0);
         end

         if (due || got) begin
            chk("resp_timing", got, due);
            if (due && rd_idx < sb.size()) begin
               chk("imem_resp",  bus.imem_resp, !sb[rd_idx].owner);
               chk("dmem_resp",  bus.dmem_resp, sb[rd_idx].owner);
               chk("imem_rdata", bus.imem_rdata, sb[rd_idx].data);
               chk("dmem_rdata", bus.dmem_rdata, sb[rd_idx].data);
               chk("l2_cleared", cur_l2, 0);
               rd_idx++;
            end
         end
         due = bus.L2_mem_resp && (rd_idx < sb.size());

         i_req = bus.imem_read | bus.imem_write;
         d_req = bus.dmem_read | bus.dmem_write;
         if (m_idle && (i_req || d_req)) begin
            exp_owner    = (i_req && d_req) ? !m_last : d_req;
            exp_rd       = exp_owner ? bus.dmem_read : bus.imem_read;
            exp_wr       = (exp_owner ? bus.dmem_write : bus.imem_write) & ~exp_rd;
            exp_addr     = exp_owner ? bus.dmem_address : bus.imem_address;
            exp_wdata    = exp_owner ? bus.dmem_wdata : bus.imem_wdata;
            expect_grant = 1'b1;
            m_idle       = 1'b0;
         end
         if (got) m_idle = 1'b1;
         prev_l2 = cur_l2;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      bus.imem_read = 1'b0; bus.imem_write = 1'b0; bus.imem_address = '0; bus.imem_wdata = '0;
      bus.dmem_read = 1'b0; bus.dmem_write = 1'b0; bus.dmem_address = '0; bus.dmem_wdata = '0;
   endtask

   task automatic reply(input logic [LINE_W-1:0] data, input bit push);
      exp_t e;
      bus.L2_mem_resp  = 1'b1;
      bus.L2_mem_rdata = data;
      if (push) begin
         e.owner = exp_owner;
         e.data  = data;
         sb.push_back(e);
      end
      step();
      bus.L2_mem_resp = 1'b0;
   endtask

   task automatic wait_l2(input string name);
      int unsigned n;
      n = 0;
      while (!(bus.L2_mem_read || bus.L2_mem_write) && n < 20) begin
         step();
         n++;
      end
      chk(name, bus.L2_mem_read | bus.L2_mem_write, 1);
   endtask

   task automatic wait_resp(input bit k, output int unsigned n);
      n = 0;
      forever begin
         @(negedge clk);
         if ((k ? bus.dmem_resp : bus.imem_resp) || n >= 20) break;
         n++;
      end
      chk("wait_resp", k ? bus.dmem_resp : bus.imem_resp, 1);
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned       n;
      int                base;
      bit                act[2];
      bit                rd[2];
      bit                wr[2];
      int unsigned       gap[2];
      int unsigned       age[2];
      bit                rsp[2];
      logic [ADDR_W-1:0] addr[2];
      logic [LINE_W-1:0] wd[2];
      logic [LINE_W-1:0] a5;
      bit                l2a;
      bit                l2_done;
      int unsigned       dly;
      int unsigned       op;
      bit                gd[$];

      clear_reqs();
      bus.L2_mem_resp  = 1'b0;
      bus.L2_mem_rdata = '0;
      repeat (3) step();
      rst = 1'b0;
      step();

      // Uncontended D read, exact cycle latency
      a5 = {(LINE_W / 8){8'hA5}};
      bus.dmem_read = 1'b1; bus.dmem_address = 16'h1230;
      step();
      chk("c1_l2_read", bus.L2_mem_read, 1);
      chk("c1_l2_addr", bus.L2_mem_address, 16'h1230);
      step(); step(); step();
      chk("c4_l2_read", bus.L2_mem_read, 1);
      reply(a5, 1'b1);
      wait_resp(1'b1, n);
      chk("c5_resp_cycle", n, 0);
      chk("c5_rdata_latched", bus.dmem_rdata, a5);
      clear_reqs();
      step();

      // Read and write together issue a read only
      bus.dmem_read = 1'b1; bus.dmem_write = 1'b1; bus.dmem_address = 16'h2000;
      bus.dmem_wdata = rand_line();
      step();
      chk("rw_read", bus.L2_mem_read, 1);
      chk("rw_write", bus.L2_mem_write, 0);
      step();
      reply(rand_line(), 1'b1);
      wait_resp(1'b1, n);
      clear_reqs();
      step();

      // D write held constant while I arrives mid-SERVE; I follows in next IDLE
      bus.dmem_write = 1'b1; bus.dmem_address = 16'h0040; bus.dmem_wdata = 1;
      step();
      chk("w_wdata", bus.L2_mem_wdata, 1);
      step();
      bus.imem_read = 1'b1; bus.imem_address = 16'h0100;
      step(); step();
      chk("w_wdata_hold", bus.L2_mem_wdata, 1);
      chk("w_write_hold", bus.L2_mem_write, 1);
      chk("w_addr_hold", bus.L2_mem_address, 16'h0040);
      reply(rand_line(), 1'b1);
      wait_resp(1'b1, n);
      bus.dmem_write = 1'b0;
      step();
      chk("i_after_w_addr", bus.L2_mem_address, 16'h0100);
      chk("i_after_w_read", bus.L2_mem_read, 1);
      reply(rand_line(), 1'b1);
      wait_resp(1'b0, n);
      clear_reqs();
      step();

      // I request dropped during SERVE still completes
      bus.imem_read = 1'b1; bus.imem_address = 16'h0300;
      step();
      bus.imem_read = 1'b0;
      step(); step();
      chk("drop_read", bus.L2_mem_read, 1);
      chk("drop_addr", bus.L2_mem_address, 16'h0300);
      reply(rand_line(), 1'b1);
      wait_resp(1'b0, n);
      clear_reqs();
      step();

      // Reset mid-SERVE abandons the transaction; late L2 resp is ignored
      bus.imem_read = 1'b1; bus.imem_address = 16'h0500;
      step(); step();
      rst = 1'b1;
      bus.imem_read = 1'b0;
      step();
      rst = 1'b0;
      step();
      reply(rand_line(), 1'b0);
      repeat (3) step();
      chk("post_rst_imem_resp", bus.imem_resp, 0);
      bus.dmem_read = 1'b1; bus.dmem_address = 16'h0600;
      step();
      chk("post_rst_grant", bus.L2_mem_read, 1);
      reply(rand_line(), 1'b1);
      wait_resp(1'b1, n);
      clear_reqs();
      step();

      // Both requesting continuously from reset release: D, I, D, I
      rst = 1'b1;
      bus.imem_read = 1'b1; bus.imem_address = 16'h0700;
      bus.dmem_read = 1'b1; bus.dmem_address = 16'h8700;
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wait_l2("fair_wait");
         gd.push_back(bus.L2_mem_address == 16'h8700);
         reply(rand_line(), 1'b1);
      end
      clear_reqs();
      step(); step();
      base = 0;
      for (int i = 0; i < 4; i++) begin
         chk("fair_grant_is_d", (gd.size() > i) ? gd[i] : 1'bx, (i % 2 == 0) ? 1 : 0);
      end
      base = base + 1;

      // Random traffic: caches with random gaps and ops, L2 with random latency
      act = '{0, 0}; gap = '{0, 0}; age = '{0, 0};
      rd = '{0, 0}; wr = '{0, 0}; addr = '{0, 0}; wd = '{0, 0};
      l2_done = 1'b0;
      dly = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         rsp[0] = bus.imem_resp;
         rsp[1] = bus.dmem_resp;
         @(posedge clk);
         #1;
         l2a = bus.L2_mem_read | bus.L2_mem_write;
         bus.L2_mem_resp = 1'b0;
         if (!l2a) begin
            l2_done = 1'b0;
            dly     = $urandom_range(0, 4);
            if ($urandom_range(0, 9) == 0) begin
               bus.L2_mem_resp  = 1'b1;
               bus.L2_mem_rdata = rand_line();
            end
         end else if (!l2_done) begin
            if (dly == 0) begin
               reply_now: begin
                  exp_t e;
                  e.owner = exp_owner;
                  e.data  = rand_line();
                  bus.L2_mem_resp  = 1'b1;
                  bus.L2_mem_rdata = e.data;
                  sb.push_back(e);
               end
               l2_done = 1'b1;
            end else begin
               dly--;
            end
         end
         for (int unsigned k = 0; k < 2; k++) begin
            if (act[k] && (rsp[k] || age[k] > 60)) begin
               chk("rand_served", rsp[k], 1);
               act[k] = 1'b0;
               gap[k] = $urandom_range(0, 3);
            end else if (act[k]) begin
               age[k]++;
            end else if (gap[k] == 0) begin
               op      = $urandom_range(0, 3);
               rd[k]   = (op != 1);
               wr[k]   = (op == 1) || (op == 2);
               addr[k] = {k[0], 15'($urandom)};
               wd[k]   = rand_line();
               act[k]  = 1'b1;
               age[k]  = 0;
            end else begin
               gap[k]--;
            end
         end
         bus.imem_read  = act[0] & rd[0]; bus.imem_write = act[0] & wr[0];
         bus.imem_address = addr[0];      bus.imem_wdata = wd[0];
         bus.dmem_read  = act[1] & rd[1]; bus.dmem_write = act[1] & wr[1];
         bus.dmem_address = addr[1];      bus.dmem_wdata = wd[1];
      end
      clear_reqs();
      bus.L2_mem_resp = 1'b0;
      repeat (5) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
